// File: rtl/bit_serial_adder.sv
// bit_serial_adder: one full-adder cell with a registered carry, LSB-first,
// one operand bit per clock, with add/subtract, carry-out and signed overflow.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   start  request, sampled only in IDLE or DONE
//   sub    0 = a+b, 1 = a-b (honoured only when SUB_EN=1), captured with start
//   a, b   WIDTH-bit operands, captured with start
//   busy   high while bits are being processed
//   done   one-cycle pulse when s/cout/ovf are valid
//   s      WIDTH-bit result, held until the next accepted start
//   cout   carry out of the MSB (subtract: 1 = no borrow)
//   ovf    two's-complement overflow
module bit_serial_adder #(
    parameter int WIDTH  = 8,
    parameter bit SUB_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CW-1:0]    count;

    logic m;
    logic x;
    logic y;
    logic sum;
    logic carry_nxt;
    logic last;

    // Subtraction is a + ~b + 1: invert b on load and seed the carry with 1.
    assign m         = sub & SUB_EN;
    assign x         = a_sr[0];
    assign y         = b_sr[0];
    assign sum       = x ^ y ^ carry;
    assign carry_nxt = (x & y) | (carry & (x ^ y));
    assign last      = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            count <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= SHIFT;
                        busy  <= 1'b1;
                        a_sr  <= a;
                        b_sr  <= b ^ {WIDTH{m}};
                        carry <= m;
                        count <= '0;
                        s     <= '0;
                        cout  <= 1'b0;
                        ovf   <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    // Result bits enter at the MSB so bit 0 lands at s[0]
                    // after WIDTH shifts.
                    s     <= {sum, s[WIDTH-1:1]};
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= carry_nxt;
                    count <= count + CW'(1);
                    if (last) begin
                        cout  <= carry_nxt;
                        // Carry into the MSB differs from carry out of it.
                        ovf   <= carry ^ carry_nxt;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// tb_bit_serial_adder: directed-vector bench for bit_serial_adder
// (WIDTH=8 with and without subtract, plus WIDTH=16).
module tb_bit_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b0;

    logic        start8 = 1'b0;
    logic        startn = 1'b0;
    logic        sub8   = 1'b0;
    logic [7:0]  a8     = '0;
    logic [7:0]  b8     = '0;
    logic        busy8, done8, cout8, ovf8;
    logic [7:0]  s8;
    logic        busyn, donen, coutn, ovfn;
    logic [7:0]  sn;

    logic        start16 = 1'b0;
    logic        sub16   = 1'b0;
    logic [15:0] a16     = '0;
    logic [15:0] b16     = '0;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] s16;

    int tests = 0;
    int fails = 0;

    bit_serial_adder #(.WIDTH(8), .SUB_EN(1'b1)) d8 (
        .clk(clk), .reset(reset), .start(start8), .sub(sub8),
        .a(a8), .b(b8), .busy(busy8), .done(done8),
        .s(s8), .cout(cout8), .ovf(ovf8)
    );

    bit_serial_adder #(.WIDTH(8), .SUB_EN(1'b0)) d8n (
        .clk(clk), .reset(reset), .start(startn), .sub(sub8),
        .a(a8), .b(b8), .busy(busyn), .done(donen),
        .s(sn), .cout(coutn), .ovf(ovfn)
    );

    bit_serial_adder #(.WIDTH(16), .SUB_EN(1'b1)) d16 (
        .clk(clk), .reset(reset), .start(start16), .sub(sub16),
        .a(a16), .b(b16), .busy(busy16), .done(done16),
        .s(s16), .cout(cout16), .ovf(ovf16)
    );

    // Launch one 8-bit operation and wait (bounded) for its done pulse.
    // lat counts edges from the accepting edge to the done edge inclusive.
    task automatic run8(input bit sel, input logic [7:0] ta,
                        input logic [7:0] tb_, input logic tsub,
                        output logic [7:0] rs, output logic rc,
                        output logic ro, output int lat, output int nbusy);
        @(negedge clk);
        a8 = ta; b8 = tb_; sub8 = tsub;
        if (sel) startn = 1'b1; else start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; startn = 1'b0;
        lat = 1; nbusy = 0;
        while (!(sel ? donen : done8) && lat < 40) begin
            if (sel ? busyn : busy8) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
        rs = sel ? sn : s8;
        rc = sel ? coutn : cout8;
        ro = sel ? ovfn : ovf8;
    endtask

    task automatic test_reset;
        #2 reset = 1'b1;
        #2;
        tests++;
        if ({busy8, done8, s8, cout8, ovf8} !== 12'h000) begin
            fails++;
            $display("FAIL reset8: got %h expected 000",
                     {busy8, done8, s8, cout8, ovf8});
        end
        tests++;
        if ({busy16, done16, s16, cout16, ovf16} !== 20'h00000) begin
            fails++;
            $display("FAIL reset16: got %h expected 00000",
                     {busy16, done16, s16, cout16, ovf16});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_add_basic;
        logic [7:0] rs; logic rc, ro; int lat, nb;
        run8(1'b0, 8'h5A, 8'h3C, 1'b0, rs, rc, ro, lat, nb);
        tests++;
        if (lat !== 9) begin
            fails++; $display("FAIL add_latency: got %0d expected 9", lat);
        end
        tests++;
        if (nb !== 8) begin
            fails++; $display("FAIL add_busy: got %0d expected 8", nb);
        end
        tests++;
        if ({rs, rc, ro} !== {8'h96, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL add_5a_3c: got s=%h c=%b v=%b expected 96 0 1",
                     rs, rc, ro);
        end
        @(posedge clk); #1;
        tests++;
        if ({done8, busy8, s8} !== {1'b0, 1'b0, 8'h96}) begin
            fails++;
            $display("FAIL add_hold: got done=%b busy=%b s=%h expected 0 0 96",
                     done8, busy8, s8);
        end
    endtask

    task automatic test_carry_overflow;
        logic [7:0] rs; logic rc, ro; int lat, nb;
        run8(1'b0, 8'hFF, 8'h01, 1'b0, rs, rc, ro, lat, nb);
        tests++;
        if ({rs, rc, ro} !== {8'h00, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL add_ff_01: got s=%h c=%b v=%b expected 00 1 0",
                     rs, rc, ro);
        end
        run8(1'b0, 8'h80, 8'h01, 1'b1, rs, rc, ro, lat, nb);
        tests++;
        if ({rs, rc, ro} !== {8'h7F, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL sub_80_01: got s=%h c=%b v=%b expected 7f 1 1",
                     rs, rc, ro);
        end
        run8(1'b0, 8'h00, 8'h00, 1'b1, rs, rc, ro, lat, nb);
        tests++;
        if ({rs, rc, ro} !== {8'h00, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL sub_00_00: got s=%h c=%b v=%b expected 00 1 0",
                     rs, rc, ro);
        end
    endtask

    task automatic test_sub_borrow;
        logic [7:0] rs; logic rc, ro; int lat, nb;
        run8(1'b0, 8'h10, 8'h20, 1'b1, rs, rc, ro, lat, nb);
        tests++;
        if ({rs, rc, ro} !== {8'hF0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL sub_10_20: got s=%h c=%b v=%b expected f0 0 0",
                     rs, rc, ro);
        end
        run8(1'b1, 8'h10, 8'h20, 1'b1, rs, rc, ro, lat, nb);
        tests++;
        if ({rs, rc, ro} !== {8'h30, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL nosub_10_20: got s=%h c=%b v=%b expected 30 0 0",
                     rs, rc, ro);
        end
        tests++;
        if (lat !== 9) begin
            fails++; $display("FAIL nosub_latency: got %0d expected 9", lat);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] oa [4];
        logic [7:0] ob [4];
        logic       os [4];
        logic [7:0] ex [3];
        int n;
        oa = '{8'h01, 8'h10, 8'h33, 8'hF0};
        ob = '{8'h02, 8'h05, 8'h44, 8'h0F};
        os = '{1'b0, 1'b1, 1'b0, 1'b0};
        ex = '{8'h03, 8'h0B, 8'h77};
        @(negedge clk);
        a8 = oa[0]; b8 = ob[0]; sub8 = os[0]; start8 = 1'b1;
        @(posedge clk); #1;
        // Change operands right after acceptance: they must not leak in.
        a8 = oa[1]; b8 = ob[1]; sub8 = os[1];
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!done8 && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            tests++;
            if (n !== 8) begin
                fails++;
                $display("FAIL b2b_period%0d: got %0d expected 9", k, n + 1);
            end
            tests++;
            if (s8 !== ex[k]) begin
                fails++;
                $display("FAIL b2b_result%0d: got %h expected %h",
                         k, s8, ex[k]);
            end
            @(posedge clk); #1;
            tests++;
            if ({busy8, s8} !== {1'b1, 8'h00}) begin
                fails++;
                $display("FAIL b2b_restart%0d: got busy=%b s=%h expected 1 00",
                         k, busy8, s8);
            end
            a8 = oa[k+2 > 3 ? 3 : k+2];
            b8 = ob[k+2 > 3 ? 3 : k+2];
            sub8 = os[k+2 > 3 ? 3 : k+2];
        end
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (s8 !== 8'hFF) begin
            fails++; $display("FAIL b2b_last: got %h expected ff", s8);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        logic [7:0] rs; logic rc, ro; int lat, nb;
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h3C; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if ({busy8, s8} !== {1'b1, 8'h60}) begin
            fails++;
            $display("FAIL mid_partial: got busy=%b s=%h expected 1 60",
                     busy8, s8);
        end
        reset = 1'b1;
        #1;
        tests++;
        if ({busy8, done8, s8, cout8, ovf8} !== 12'h000) begin
            fails++;
            $display("FAIL mid_reset: got %h expected 000",
                     {busy8, done8, s8, cout8, ovf8});
        end
        @(negedge clk);
        reset = 1'b0;
        run8(1'b0, 8'h5A, 8'h3C, 1'b0, rs, rc, ro, lat, nb);
        tests++;
        if ({rs, rc, ro, lat} !== {8'h96, 1'b0, 1'b1, 32'd9}) begin
            fails++;
            $display("FAIL mid_rerun: got s=%h c=%b v=%b lat=%0d expected 96 0 1 9",
                     rs, rc, ro, lat);
        end
    endtask

    task automatic test_width16;
        int lat;
        @(negedge clk);
        a16 = 16'h7FFF; b16 = 16'h0001; sub16 = 1'b0; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        lat = 1;
        while (!done16 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        tests++;
        if (lat !== 17) begin
            fails++; $display("FAIL w16_latency: got %0d expected 17", lat);
        end
        tests++;
        if ({s16, cout16, ovf16} !== {16'h8000, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL w16_result: got s=%h c=%b v=%b expected 8000 0 1",
                     s16, cout16, ovf16);
        end
    endtask

    initial begin
        test_reset;
        test_add_basic;
        test_carry_overflow;
        test_sub_borrow;
        test_back_to_back;
        test_reset_mid;
        test_width16;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
